upload_packer: RTL



---
 rtl/upload_packer_if.sv | 22 ++
 rtl/upload_packer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/upload_packer_if.sv
// Handshake bundle between a protocol engine's upload stream and the CDC TX FIFO.
// The slave modport is the packer; the master modport is the engine/FIFO side.
interface upload_packer_if;
  logic       upload_req;
  logic [7:0] upload_data;
  logic [7:0] upload_source;
  logic       upload_valid;
  logic       upload_ready;
  logic [7:0] pack_data;
  logic       pack_valid;
  logic       pack_ready;

  modport slave (
    input  upload_req, upload_data, upload_source, upload_valid, pack_ready,
    output upload_ready, pack_data, pack_valid
  );

  modport master (
    output upload_req, upload_data, upload_source, upload_valid, pack_ready,
    input  upload_ready, pack_data, pack_valid
  );
endinterface

// File: rtl/upload_packer.sv
// Buffers upload bytes per source and emits them as framed packets:
// AA 44 src len_hi len_lo payload... csum (csum excludes the AA 44 preamble).
module upload_packer #(
  parameter int unsigned MAX_PAYLOAD  = 256,
  parameter int unsigned IDLE_TIMEOUT = 1000
) (
  input  logic               clk,
  input  logic               rst,
  upload_packer_if.slave     bus
);

  localparam int unsigned AW       = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam logic [15:0] MAX_CNT  = 16'(MAX_PAYLOAD);
  localparam logic [31:0] IDLE_LIM = 32'(IDLE_TIMEOUT);

  typedef enum logic [2:0] {
    S_COLLECT, S_HDR0, S_HDR1, S_SRC, S_LEN_HI, S_LEN_LO, S_PAYLOAD, S_CSUM
  } state_t;

  state_t      r_state;
  logic [7:0]  r_mem [MAX_PAYLOAD];
  logic [15:0] r_count;
  logic [15:0] r_rd_ptr;
  logic [31:0] r_idle;
  logic [7:0]  r_cur_src;
  logic [7:0]  r_pend_data;
  logic [7:0]  r_pend_src;
  logic        r_pend_valid;
  logic [7:0]  r_psum;
  logic [7:0]  r_pack_data;
  logic        r_pack_valid;
  logic        r_upload_ready;

  logic        w_accept;
  logic        w_new_src;
  logic [15:0] w_count_inc;
  logic        w_close;
  logic        w_csum_done;
  logic [7:0]  w_csum;
  logic [7:0]  w_rd_byte;
  logic        w_mem_we;
  logic [AW-1:0] w_mem_addr;
  logic [7:0]  w_mem_wdata;
  logic        w_unused_req;

  assign w_unused_req = bus.upload_req;

  // r_upload_ready is only ever high in S_COLLECT, so it alone qualifies an accept.
  assign w_accept    = r_upload_ready && bus.upload_valid;
  assign w_new_src   = (r_count != 16'd0) && (bus.upload_source != r_cur_src);
  assign w_count_inc = r_count + 16'd1;
  assign w_close     = (w_accept && w_new_src)
                     || (w_accept && (w_count_inc == MAX_CNT))
                     || (!w_accept && (r_count != 16'd0)
                         && ((r_count == MAX_CNT) || (r_idle == IDLE_LIM)));
  assign w_csum_done = (r_state == S_CSUM) && bus.pack_ready;
  assign w_csum      = r_psum + r_cur_src + r_count[15:8] + r_count[7:0];
  assign w_rd_byte   = r_mem[r_rd_ptr[AW-1:0]];

  // The pending byte of a source change is written as byte 0 of the next frame.
  assign w_mem_we    = (w_accept && !w_new_src) || (w_csum_done && r_pend_valid);
  assign w_mem_addr  = w_csum_done ? {AW{1'b0}} : r_count[AW-1:0];
  assign w_mem_wdata = w_csum_done ? r_pend_data : bus.upload_data;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_COLLECT;
      r_count        <= 16'd0;
      r_rd_ptr       <= 16'd0;
      r_idle         <= 32'd0;
      r_cur_src      <= 8'h00;
      r_pend_data    <= 8'h00;
      r_pend_src     <= 8'h00;
      r_pend_valid   <= 1'b0;
      r_psum         <= 8'h00;
      r_pack_data    <= 8'h00;
      r_pack_valid   <= 1'b0;
      r_upload_ready <= 1'b0;
    end else begin
      case (r_state)
        S_COLLECT: begin
          if (w_accept && w_new_src) begin
            r_pend_data  <= bus.upload_data;
            r_pend_src   <= bus.upload_source;
            r_pend_valid <= 1'b1;
          end else if (w_accept) begin
            r_count <= w_count_inc;
            r_psum  <= r_psum + bus.upload_data;
            if (r_count == 16'd0) begin
              r_cur_src <= bus.upload_source;
            end
          end
          if (w_accept || w_close || (r_count == 16'd0)) begin
            r_idle <= 32'd0;
          end else if (r_idle < IDLE_LIM) begin
            r_idle <= r_idle + 32'd1;
          end
          if (w_close) begin
            r_state        <= S_HDR0;
            r_pack_valid   <= 1'b1;
            r_pack_data    <= 8'hAA;
            r_upload_ready <= 1'b0;
          end else begin
            r_upload_ready <= !r_pend_valid && (r_count < MAX_CNT);
          end
        end
        S_HDR0: if (bus.pack_ready) begin
          r_pack_data <= 8'h44;
          r_state     <= S_HDR1;
        end
        S_HDR1: if (bus.pack_ready) begin
          r_pack_data <= r_cur_src;
          r_state     <= S_SRC;
        end
        S_SRC: if (bus.pack_ready) begin
          r_pack_data <= r_count[15:8];
          r_state     <= S_LEN_HI;
        end
        S_LEN_HI: if (bus.pack_ready) begin
          r_pack_data <= r_count[7:0];
          r_state     <= S_LEN_LO;
        end
        S_LEN_LO: if (bus.pack_ready) begin
          r_pack_data <= w_rd_byte;
          r_rd_ptr    <= 16'd1;
          r_state     <= S_PAYLOAD;
        end
        // r_rd_ptr runs one ahead of the byte on pack_data, so the next read is ready.
        S_PAYLOAD: if (bus.pack_ready) begin
          if (r_rd_ptr == r_count) begin
            r_pack_data <= w_csum;
            r_state     <= S_CSUM;
          end else begin
            r_pack_data <= w_rd_byte;
            r_rd_ptr    <= r_rd_ptr + 16'd1;
          end
        end
        S_CSUM: if (bus.pack_ready) begin
          r_pack_valid   <= 1'b0;
          r_pack_data    <= 8'h00;
          r_state        <= S_COLLECT;
          r_rd_ptr       <= 16'd0;
          r_idle         <= 32'd0;
          r_upload_ready <= !r_pend_valid || (MAX_CNT > 16'd1);
          if (r_pend_valid) begin
            r_count      <= 16'd1;
            r_cur_src    <= r_pend_src;
            r_psum       <= r_pend_data;
            r_pend_valid <= 1'b0;
          end else begin
            r_count <= 16'd0;
            r_psum  <= 8'h00;
          end
        end
        default: begin
          r_state        <= S_COLLECT;
          r_pack_valid   <= 1'b0;
          r_upload_ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.upload_ready = r_upload_ready;
  assign bus.pack_data    = r_pack_data;
  assign bus.pack_valid   = r_pack_valid;

endmodule
